// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//   Per-channel push-button conditioning: a 2-flop synchroniser, then a
//   debouncer that accepts a level change only after DEB_CYCLES consecutive
//   stable cycles, then press/release edge pulses. With BTN_AUTOREPEAT_EN
//   defined, a held button also produces auto-repeat press pulses: the first
//   comes REPEAT_DELAY cycles after the accepted press, and later ones follow
//   every REPEAT_RATE cycles.
//
// Configuration macro:
//   BTN_AUTOREPEAT_EN  defined   -> IDLE/HELD FSM and repeat counter present
//                      undefined -> one press pulse per press, btn_rpt tied 0,
//                                   REPEAT_DELAY / REPEAT_RATE ignored
//
// Ports:
//   Clk100M      in   1      system clock, rising edge
//   reset_n      in   1      asynchronous active-low reset
//   btn_raw      in   N_BTN  raw bouncing levels, 1 = pressed
//   btn_level    out  N_BTN  debounced level
//   btn_press    out  N_BTN  1-cycle pulse per accepted press or auto-repeat
//   btn_release  out  N_BTN  1-cycle pulse per accepted release
//   btn_rpt      out  N_BTN  high alongside btn_press for auto-repeat pulses
// -----------------------------------------------------------------------------
module btn_conditioner #(
   parameter int N_BTN        = 3,
   parameter int DEB_CYCLES   = 1000000,
   parameter int REPEAT_DELAY = 50000000,
   parameter int REPEAT_RATE  = 10000000
) (
   input  logic             Clk100M,
   input  logic             reset_n,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_rpt
);

   // The stored debounce count never exceeds DEB_CYCLES-1, because acceptance
   // clears it. The repeat counter holds values 1..max(DELAY, RATE).
   localparam int DEB_W = $clog2(DEB_CYCLES + 1);

`ifdef BTN_AUTOREPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RPT_W   = $clog2(RPT_MAX + 1);

   typedef enum logic {ST_IDLE, ST_HELD} state_t;
`endif

   if (DEB_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
      $error("btn_conditioner: DEB_CYCLES, REPEAT_DELAY and REPEAT_RATE must be >= 1");
   end

   for (genvar g = 0; g < N_BTN; g++) begin : g_ch
      logic [1:0]       r_sync;
      logic [DEB_W-1:0] r_deb_cnt;
      logic             r_level;
      logic             r_press;
      logic             r_release;
      logic             w_accept;
      logic             w_rise;
      logic             w_fall;

      // Stage: synchroniser (r_sync[1] is the only copy used downstream)
      always_ff @(posedge Clk100M or negedge reset_n) begin
         if (!reset_n) r_sync <= '0;
         else          r_sync <= {r_sync[0], btn_raw[g]};
      end

      // Stage: debounce. This cycle would be the DEB_CYCLES-th consecutive
      // cycle that differs from the accepted level, so flip now.
      assign w_accept = (r_sync[1] != r_level) &&
                        (r_deb_cnt == DEB_W'(DEB_CYCLES - 1));
      assign w_rise   = w_accept & ~r_level;
      assign w_fall   = w_accept &  r_level;

      always_ff @(posedge Clk100M or negedge reset_n) begin
         if (!reset_n) begin
            r_deb_cnt <= '0;
            r_level   <= 1'b0;
         end else if (r_sync[1] == r_level) begin
            r_deb_cnt <= '0;
         end else if (w_accept) begin
            r_deb_cnt <= '0;
            r_level   <= ~r_level;
         end else begin
            r_deb_cnt <= r_deb_cnt + DEB_W'(1);
         end
      end

`ifdef BTN_AUTOREPEAT_EN
      state_t           r_state;
      logic [RPT_W-1:0] r_rpt_cnt;
      logic             r_rpt;

      // Stage: press/repeat FSM. The pulses are registered on the same edge as
      // the level flip, so they line up with the first cycle of the new level.
      always_ff @(posedge Clk100M or negedge reset_n) begin
         if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_rpt_cnt <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_rpt     <= 1'b0;
         end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_rpt     <= 1'b0;
            case (r_state)
               ST_IDLE: begin
                  if (w_rise) begin
                     r_state   <= ST_HELD;
                     r_rpt_cnt <= RPT_W'(REPEAT_DELAY);
                     r_press   <= 1'b1;
                  end
               end
               ST_HELD: begin
                  // A release takes priority over a repeat at terminal count.
                  if (w_fall) begin
                     r_state   <= ST_IDLE;
                     r_release <= 1'b1;
                  end else if (r_rpt_cnt == RPT_W'(1)) begin
                     r_rpt_cnt <= RPT_W'(REPEAT_RATE);
                     r_press   <= 1'b1;
                     r_rpt     <= 1'b1;
                  end else begin
                     r_rpt_cnt <= r_rpt_cnt - RPT_W'(1);
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end

      assign btn_rpt[g] = r_rpt;
`else
      // Stage: edge pulses
      always_ff @(posedge Clk100M or negedge reset_n) begin
         if (!reset_n) begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
         end else begin
            r_press   <= w_rise;
            r_release <= w_fall;
         end
      end

      assign btn_rpt[g] = 1'b0;
`endif

      assign btn_level[g]   = r_level;
      assign btn_press[g]   = r_press;
      assign btn_release[g] = r_release;
   end

endmodule
